// File: rtl/rle_row_compressor.sv
// rle_row_compressor: per-lane run-length encoder over one row of pixel beats.
// Latency: a run leaves as a token the cycle after the beat that breaks it, or during the row-end flush.
// Backpressure: input stalls (o_in_ready=0) whenever any token is pending; tokens hold steady until i_out_ready.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   i_pixel/i_valid    input beat, lane k = i_pixel[k*ChannelWidth +: ChannelWidth]
//   o_in_ready         beat accepted when i_valid && o_in_ready
//   o_valid/i_out_ready token handshake; token = {o_channel, o_value, o_count}
//   o_last             marks the final token of a row
//   o_row_done         one-cycle pulse once the whole row has been emitted
module rle_row_compressor #(
  parameter int NumChannels   = 2,
  parameter int ChannelWidth  = 8,
  parameter int RowPixelWidth = 640,
  parameter int CountWidth    = 8,
  localparam int ChIdxWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NumChannels*ChannelWidth-1:0] i_pixel,
  input  logic                                i_valid,
  output logic                                o_in_ready,
  output logic                                o_valid,
  input  logic                                i_out_ready,
  output logic [ChIdxWidth-1:0]               o_channel,
  output logic [ChannelWidth-1:0]             o_value,
  output logic [CountWidth-1:0]               o_count,
  output logic                                o_last,
  output logic                                o_row_done
);

  localparam int PixCntWidth = (RowPixelWidth > 1) ? $clog2(RowPixelWidth) : 1;
  localparam logic [CountWidth-1:0]  MaxRun  = {CountWidth{1'b1}};
  localparam logic [PixCntWidth-1:0] LastPix = PixCntWidth'(RowPixelWidth - 1);

  typedef enum logic {ACCEPT, FLUSH} state_e;

  state_e                   state_q, state_d;
  logic [PixCntWidth-1:0]   pix_cnt_q, pix_cnt_d;
  logic [ChannelWidth-1:0]  run_val_q  [NumChannels];
  logic [ChannelWidth-1:0]  run_val_d  [NumChannels];
  logic [CountWidth-1:0]    run_cnt_q  [NumChannels];
  logic [CountWidth-1:0]    run_cnt_d  [NumChannels];
  logic [NumChannels-1:0]   pend_vld_q, pend_vld_d;
  logic [ChannelWidth-1:0]  pend_val_q [NumChannels];
  logic [ChannelWidth-1:0]  pend_val_d [NumChannels];
  logic [CountWidth-1:0]    pend_cnt_q [NumChannels];
  logic [CountWidth-1:0]    pend_cnt_d [NumChannels];

  logic                     any_pend, any_run, single_pend;
  logic                     in_fire, out_fire;
  logic [ChIdxWidth-1:0]    sel_idx;
  logic [ChannelWidth-1:0]  lane;

  always_comb begin
    any_run = 1'b0;
    for (int k = 0; k < NumChannels; k++) begin
      if (run_cnt_q[k] != '0) any_run = 1'b1;
    end
  end

  // Lowest-index occupied slot wins; scanning downward leaves the lowest hit.
  always_comb begin
    sel_idx = '0;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      if (pend_vld_q[k]) sel_idx = ChIdxWidth'(k);
    end
  end

  assign any_pend    = |pend_vld_q;
  // Clearing the lowest set bit leaves zero only when at most one slot is occupied.
  assign single_pend = (pend_vld_q & (pend_vld_q - NumChannels'(1))) == '0;

  // Outputs are forced quiet while reset is asserted, whatever the stored state.
  assign o_valid    = !RST && any_pend;
  assign o_in_ready = !RST && (state_q == ACCEPT) && !any_pend;
  assign o_channel  = o_valid ? sel_idx : '0;
  assign o_value    = o_valid ? pend_val_q[sel_idx] : '0;
  assign o_count    = o_valid ? pend_cnt_q[sel_idx] : '0;
  assign o_last     = o_valid && (state_q == FLUSH) && single_pend && !any_run;
  assign o_row_done = !RST && (state_q == FLUSH) && !any_pend && !any_run;

  assign in_fire  = i_valid && o_in_ready;
  assign out_fire = o_valid && i_out_ready;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    run_val_d  = run_val_q;
    run_cnt_d  = run_cnt_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    pend_cnt_d = pend_cnt_q;
    lane       = '0;

    if (out_fire) pend_vld_d[sel_idx] = 1'b0;

    // Slots are only loaded while all are empty, so a load never meets a drain.
    case (state_q)
      ACCEPT: begin
        if (in_fire) begin
          for (int k = 0; k < NumChannels; k++) begin
            lane = i_pixel[k*ChannelWidth +: ChannelWidth];
            if (run_cnt_q[k] == '0) begin
              run_val_d[k] = lane;
              run_cnt_d[k] = CountWidth'(1);
            end else if (lane == run_val_q[k] && run_cnt_q[k] != MaxRun) begin
              run_cnt_d[k] = run_cnt_q[k] + CountWidth'(1);
            end else begin
              // Value change or saturated counter: retire the run, start afresh.
              pend_vld_d[k] = 1'b1;
              pend_val_d[k] = run_val_q[k];
              pend_cnt_d[k] = run_cnt_q[k];
              run_val_d[k]  = lane;
              run_cnt_d[k]  = CountWidth'(1);
            end
          end
          if (pix_cnt_q == LastPix) begin
            pix_cnt_d = '0;
            state_d   = FLUSH;
          end else begin
            pix_cnt_d = pix_cnt_q + PixCntWidth'(1);
          end
        end
      end
      FLUSH: begin
        if (!any_pend) begin
          if (any_run) begin
            for (int k = 0; k < NumChannels; k++) begin
              if (run_cnt_q[k] != '0) begin
                pend_vld_d[k] = 1'b1;
                pend_val_d[k] = run_val_q[k];
                pend_cnt_d[k] = run_cnt_q[k];
                run_cnt_d[k]  = '0;
              end
            end
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ACCEPT;
      pix_cnt_q  <= '0;
      pend_vld_q <= '0;
      for (int k = 0; k < NumChannels; k++) begin
        run_val_q[k]  <= '0;
        run_cnt_q[k]  <= '0;
        pend_val_q[k] <= '0;
        pend_cnt_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      pend_vld_q <= pend_vld_d;
      run_val_q  <= run_val_d;
      run_cnt_q  <= run_cnt_d;
      pend_val_q <= pend_val_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

endmodule
